// File: rtl/jtag_master.sv
// JTAG scan master: TAP reset, IR scan and DR scan over TCK/TMS/TDI/TDO.
// Define JTAG_MASTER_TDO_CAPTURE_EN to capture TDO into rsp_data.
module jtag_master #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_type,
    input  logic [5:0]        cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              tck,
    output logic              tms,
    output logic              tdi,
    input  logic              tdo
);

    typedef enum logic [2:0] {
        INIT_RST, IDLE, PRE, SHIFT, POST, RSP
    } state_t;

    localparam logic [5:0] MAXN = 6'(DATA_W);

    state_t            state_q, state_d, after;
    logic              ph_q, ph_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [5:0]        n_q, n_d;
    logic [5:0]        span;
    logic [1:0]        typ_q, typ_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              err_q, err_d;
    logic              last, active, bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT_RST;
            ph_q    <= 1'b0;
            cnt_q   <= '0;
            n_q     <= '0;
            typ_q   <= '0;
            sh_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            typ_q   <= typ_d;
            sh_q    <= sh_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        typ_d     = typ_q;
        sh_d      = sh_q;
        err_d     = err_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        tms       = 1'b0;
        span      = 6'd1;
        after     = IDLE;
        active    = 1'b0;
        bad       = 1'b0;

        // TMS path length and successor state of each TCK-driven state
        unique case (state_q)
            INIT_RST: begin
                span  = 6'd6;
                after = IDLE;
            end
            PRE: begin
                span  = (typ_q == 2'd0) ? 6'd6 :
                        (typ_q == 2'd1) ? 6'd4 : 6'd3;
                after = (typ_q == 2'd0) ? RSP : SHIFT;
            end
            SHIFT: begin
                span  = n_q;
                after = POST;
            end
            POST: begin
                span  = 6'd2;
                after = RSP;
            end
            default: ;
        endcase

        last = (cnt_q == span - 6'd1);

        unique case (state_q)
            INIT_RST: begin
                active = 1'b1;
                tms    = (cnt_q < 6'd5);
            end
            PRE: begin
                active = 1'b1;
                unique case (typ_q)
                    2'd0:    tms = (cnt_q < 6'd5);
                    2'd1:    tms = (cnt_q < 6'd2);
                    default: tms = (cnt_q == 6'd0);
                endcase
            end
            SHIFT: begin
                active = 1'b1;
                tms    = last;
            end
            POST: begin
                active = 1'b1;
                tms    = (cnt_q == 6'd0);
            end
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    bad     = (cmd_type == 2'd3) ||
                              (cmd_type != 2'd0 && cmd_len == 6'd0);
                    typ_d   = cmd_type;
                    n_d     = (cmd_len > MAXN) ? MAXN : cmd_len;
                    sh_d    = cmd_data;
                    err_d   = bad;
                    cnt_d   = '0;
                    ph_d    = 1'b0;
                    state_d = bad ? RSP : PRE;
                end
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: ;
        endcase

        if (active) begin
            if (!ph_q) begin
                ph_d = 1'b1;
            end else begin
                ph_d = 1'b0;
                if (state_q == SHIFT) sh_d = sh_q >> 1;
                if (last) begin
                    cnt_d   = '0;
                    state_d = after;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
        end

        tck = active && ph_q;
        tdi = (state_q == SHIFT) && sh_q[0];
    end

    assign rsp_err = err_q;

`ifdef JTAG_MASTER_TDO_CAPTURE_EN
    logic [DATA_W-1:0] cap_q;

    // TDO is taken on the edge that raises TCK, i.e. end of the low phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cap_q <= '0;
        else if (state_q == IDLE && cmd_valid)
            cap_q <= '0;
        else if (state_q == SHIFT && !ph_q)
            cap_q <= cap_q | (DATA_W'(tdo) << cnt_q);
    end

    assign rsp_data = cap_q;
`else
    logic unused_tdo;
    assign unused_tdo = tdo;
    assign rsp_data   = '0;
`endif

endmodule
